// File: rtl/fifo_ptr_pkg.sv
// Shared pointer types and gray/binary helpers for the FIFO pointer crossing.
package fifo_ptr_pkg;

  localparam int PTR_SIZE = 4;
  localparam int DEPTH    = 2 ** (PTR_SIZE - 1);

  typedef logic [PTR_SIZE-1:0] ptr_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dec_state_e;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_SIZE-1] = g[PTR_SIZE-1];
    for (int i = PTR_SIZE - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input ptr_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_SIZE; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_decoder_gray_to_bin.sv
// Combinational gray-to-binary decode; inverse of the pointer encoder.
module gray_to_bin
  import fifo_ptr_pkg::*;
#(
  parameter int SIZE = PTR_SIZE
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[SIZE-1] = gray[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
  end

endmodule

// File: rtl/gray_ptr_decoder.sv
// Read-side receiver of the gray pointer: synchronize, decode, and derive
// occupancy, empty/full and sticky error flags against the local pointer.
module gray_ptr_decoder
  import fifo_ptr_pkg::*;
#(
  parameter int SIZE        = PTR_SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] gray_in,
  input  logic [SIZE-1:0] local_bin,
  input  logic            clr_err,
  output logic [SIZE-1:0] bin_out,
  output logic            bin_valid,
  output logic [SIZE-1:0] count,
  output logic            empty,
  output logic            full,
  output logic            err_step,
  output logic            err_range
);

  localparam int                CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(SYNC_STAGES);
  localparam logic [SIZE-1:0]   DEPTH_V   = SIZE'(2 ** (SIZE - 1));

  function automatic int unsigned popcount_w(input logic [SIZE-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SIZE; i++) n += 32'(v[i]);
    return n;
  endfunction

  logic [SIZE-1:0]  sync_q [SYNC_STAGES];
  logic [SIZE-1:0]  sync_last;
  logic [SIZE-1:0]  gray_prev;
  logic [SIZE-1:0]  bin_p0;
  logic [SIZE-1:0]  count_p0;
  logic [CNT_W-1:0] fill_cnt;
  dec_state_e       state;
  logic             run_next;
  logic             step_bad;
  logic             range_bad;

  // Stage boundary: metastability synchronizer on the asynchronous gray pointer.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    if (s == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!rst_n) sync_q[s] <= '0;
        else        sync_q[s] <= gray_in;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (!rst_n) sync_q[s] <= '0;
        else        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  gray_to_bin #(.SIZE(SIZE)) u_gray_to_bin (
    .gray (sync_last),
    .bin  (bin_p0)
  );

  // Flags follow the state we are entering so bin_valid and empty/full agree.
  assign count_p0  = bin_p0 - local_bin;
  assign run_next  = (state == RUN) || (fill_cnt == FILL_LAST);
  assign step_bad  = (state == RUN) && (popcount_w(sync_last ^ gray_prev) > 1);
  assign range_bad = (state == RUN) && (count_p0 > DEPTH_V);

  // Stage boundary: registered decode, occupancy and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      bin_valid <= 1'b0;
      gray_prev <= '0;
      bin_out   <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      err_step  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      gray_prev <= sync_last;
      bin_out   <= bin_p0;
      count     <= count_p0;
      empty     <= !run_next || (count_p0 == '0);
      full      <= run_next && (count_p0 == DEPTH_V);
      bin_valid <= run_next;
      err_step  <= step_bad  || (err_step  && !clr_err);
      err_range <= range_bad || (err_range && !clr_err);
      case (state)
        FILL: begin
          if (fill_cnt == FILL_LAST) state <= RUN;
          else                       fill_cnt <= fill_cnt + 1'b1;
        end
        RUN:     state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Directed bench for gray_ptr_decoder with SIZE=4, SYNC_STAGES=2.
module tb_gray_ptr_decoder;
  import fifo_ptr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clr_err;
  logic [3:0] gray_in, local_bin, bin_out, count;
  logic       bin_valid, empty, full, err_step, err_range;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_ptr_decoder #(.SIZE(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .local_bin (local_bin),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err_step  (err_step),
    .err_range (err_range)
  );

  typedef struct {
    logic [3:0] lb;
    logic [3:0] gray;
    int         exp_bin;
    int         exp_cnt;
    bit         exp_empty;
    bit         exp_full;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  initial begin
    int prev_bin;

    tbl[0]  = '{4'd0,  4'b0000, 0,  0, 1'b1, 1'b0};
    tbl[1]  = '{4'd0,  4'b0001, 1,  1, 1'b0, 1'b0};
    tbl[2]  = '{4'd0,  4'b0011, 2,  2, 1'b0, 1'b0};
    tbl[3]  = '{4'd0,  4'b0010, 3,  3, 1'b0, 1'b0};
    tbl[4]  = '{4'd0,  4'b0110, 4,  4, 1'b0, 1'b0};
    tbl[5]  = '{4'd0,  4'b0111, 5,  5, 1'b0, 1'b0};
    tbl[6]  = '{4'd0,  4'b0101, 6,  6, 1'b0, 1'b0};
    tbl[7]  = '{4'd0,  4'b0100, 7,  7, 1'b0, 1'b0};
    tbl[8]  = '{4'd0,  4'b1100, 8,  8, 1'b0, 1'b1};
    tbl[9]  = '{4'd4,  4'b1101, 9,  5, 1'b0, 1'b0};
    tbl[10] = '{4'd4,  4'b1111, 10, 6, 1'b0, 1'b0};
    tbl[11] = '{4'd4,  4'b1110, 11, 7, 1'b0, 1'b0};
    tbl[12] = '{4'd4,  4'b1010, 12, 8, 1'b0, 1'b1};
    tbl[13] = '{4'd6,  4'b1011, 13, 7, 1'b0, 1'b0};
    tbl[14] = '{4'd6,  4'b1001, 14, 8, 1'b0, 1'b1};
    tbl[15] = '{4'd8,  4'b1000, 15, 7, 1'b0, 1'b0};
    tbl[16] = '{4'd8,  4'b0000, 0,  8, 1'b0, 1'b1};
    tbl[17] = '{4'd14, 4'b0001, 1,  3, 1'b0, 1'b0};

    // Reset with a non-zero remote pointer present
    rst_n = 1'b0; clr_err = 1'b0; local_bin = 4'd0; gray_in = 4'b1111;
    step(3);
    chk("rst_bin_out", 32'(bin_out), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_bin_valid", 32'(bin_valid), 0);
    chk("rst_err_step", 32'(err_step), 0);
    chk("rst_err_range", 32'(err_range), 0);

    gray_in = 4'b0000;
    rst_n = 1'b1;
    step(1);
    chk("fill_valid_e1", 32'(bin_valid), 0);
    step(1);
    chk("fill_valid_e2", 32'(bin_valid), 0);
    chk("fill_empty_e2", 32'(empty), 1);
    step(1);
    chk("fill_valid_e3", 32'(bin_valid), 1);
    chk("fill_empty_e3", 32'(empty), 1);

    // Sweep and wrap through the table
    prev_bin = 0;
    for (int i = 0; i < 18; i++) begin
      local_bin = tbl[i].lb;
      gray_in   = tbl[i].gray;
      step(2);
      chk($sformatf("lat_bin_out[%0d]", i), 32'(bin_out), 32'(prev_bin));
      step(1);
      chk($sformatf("bin_out[%0d]", i), 32'(bin_out), 32'(tbl[i].exp_bin));
      chk($sformatf("count[%0d]", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("empty[%0d]", i), 32'(empty), 32'(tbl[i].exp_empty));
      chk($sformatf("full[%0d]", i), 32'(full), 32'(tbl[i].exp_full));
      chk($sformatf("err_step[%0d]", i), 32'(err_step), 0);
      chk($sformatf("err_range[%0d]", i), 32'(err_range), 0);
      step(1);
      chk($sformatf("hold_bin_out[%0d]", i), 32'(bin_out), 32'(tbl[i].exp_bin));
      prev_bin = tbl[i].exp_bin;
    end

    // Illegal 2-bit gray step, sticky hold, clear, clear-vs-set priority
    gray_in = 4'b0000;
    step(4);
    chk("jump_pre_err", 32'(err_step), 0);
    gray_in = 4'b0011;
    step(2);
    chk("jump_err_e2", 32'(err_step), 0);
    step(1);
    chk("jump_err_e3", 32'(err_step), 1);
    chk("jump_bin_out", 32'(bin_out), 2);
    chk("jump_count", 32'(count), 4);
    step(3);
    chk("jump_err_held", 32'(err_step), 1);
    clr_pulse();
    chk("jump_err_clr", 32'(err_step), 0);
    gray_in = 4'b0000;
    step(3);
    chk("jump2_err", 32'(err_step), 1);
    gray_in = 4'b0011;
    step(2);
    clr_pulse();
    chk("clr_vs_set", 32'(err_step), 1);
    step(1);
    chk("clr_vs_set_held", 32'(err_step), 1);
    clr_pulse();
    chk("jump_err_clr2", 32'(err_step), 0);
    chk("jump_no_range", 32'(err_range), 0);

    // Out-of-range occupancy, reached with legal single-bit steps
    local_bin = 4'd0;
    for (int v = 3; v <= 9; v++) begin
      gray_in = bin2gray(4'(v));
      step(4);
    end
    chk("range_bin_out", 32'(bin_out), 9);
    chk("range_count", 32'(count), 9);
    chk("range_err", 32'(err_range), 1);
    chk("range_full", 32'(full), 0);
    chk("range_empty", 32'(empty), 0);
    chk("range_no_step", 32'(err_step), 0);
    clr_pulse();
    chk("range_clr_persist", 32'(err_range), 1);
    local_bin = 4'd1;
    step(1);
    chk("range_full_at_8", 32'(full), 1);
    chk("range_sticky", 32'(err_range), 1);
    clr_pulse();
    chk("range_clr", 32'(err_range), 0);

    // Reset in the middle of operation
    local_bin = 4'd4;
    step(1);
    chk("mid_count_pre", 32'(count), 5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_count", 32'(count), 0);
    chk("mid_bin_out", 32'(bin_out), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_full", 32'(full), 0);
    chk("mid_valid", 32'(bin_valid), 0);
    chk("mid_err_step", 32'(err_step), 0);
    chk("mid_err_range", 32'(err_range), 0);
    step(2);
    chk("mid_valid_e2", 32'(bin_valid), 0);
    chk("mid_empty_e2", 32'(empty), 1);
    step(1);
    chk("mid_valid_e3", 32'(bin_valid), 1);
    chk("mid_bin_out_e3", 32'(bin_out), 9);
    chk("mid_count_e3", 32'(count), 5);
    chk("mid_empty_e3", 32'(empty), 0);
    step(1);
    chk("mid_err_step_after", 32'(err_step), 0);
    chk("mid_err_range_after", 32'(err_range), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
